seg_display_scanner: RTL

SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

---
 rtl/seg_display_scanner_pkg.sv | 41 ++++
 rtl/seg_display_scanner_hex_to_7seg.sv | 32 +++
 rtl/seg_display_scanner.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg_display_scanner_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_display_scanner_pkg;

    localparam logic [6:0] BLANK_SEG = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result++;
            rest = rest >> 1;
        end
        return result;
    endfunction

    // Select/counter width that never collapses to zero bits.
    function automatic int sel_width(input int value);
        return (value > 1) ? clog2(value) : 1;
    endfunction

endpackage

// File: rtl/seg_display_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_7seg
    import seg_display_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = BLANK_SEG;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = BLANK_SEG;
        endcase
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment scanner with per-frame channel snapshots,
// auto-rotation, freeze and leading-zero blanking.
module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int NUM_CH        = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int ROTATE_FRAMES = 256
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [NUM_CH*NUM_DIGITS*4-1:0]   ch_data,
    input  logic [sel_width(NUM_CH)-1:0]     ch_sel,
    input  logic                             auto_rotate,
    input  logic                             blank_lz,
    input  logic                             freeze,
    output logic [6:0]                       out7,
    output logic [NUM_DIGITS-1:0]            en_out,
    output logic [sel_width(NUM_CH)-1:0]     cur_ch
);

    localparam int DATA_W = NUM_DIGITS * 4;
    localparam int CH_W   = sel_width(NUM_CH);
    localparam int DIG_W  = sel_width(NUM_DIGITS);
    localparam int PRE_W  = sel_width(REFRESH_DIV);
    localparam int FRM_W  = sel_width(ROTATE_FRAMES);

    logic [PRE_W-1:0]      presc;
    logic [DIG_W-1:0]      digit;
    logic [FRM_W-1:0]      frame_cnt;
    logic [DATA_W-1:0]     snapshot;
    logic [DATA_W-1:0]     sel_data;
    logic [CH_W-1:0]       manual_ch;
    logic [CH_W-1:0]       next_ch;
    logic                  tick;
    logic                  frame_end;
    logic [3:0]            nibble;
    logic [6:0]            glyph;
    logic                  blank_cur;
    logic [NUM_DIGITS-1:0] digit_onehot;
    logic [NUM_DIGITS-1:0] nz;

    assign tick      = (presc == PRE_W'(REFRESH_DIV - 1));
    assign frame_end = tick && (digit == DIG_W'(NUM_DIGITS - 1));
    assign manual_ch = (int'(ch_sel) < NUM_CH) ? ch_sel : '0;

    // Channel that becomes current if this is an unfrozen frame boundary.
    always_comb begin
        next_ch = cur_ch;
        if (!auto_rotate)
            next_ch = manual_ch;
        else if (frame_cnt == FRM_W'(ROTATE_FRAMES - 1))
            next_ch = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            if (next_ch == CH_W'(c))
                sel_data = ch_data[c*DATA_W +: DATA_W];
    end

    always_comb begin
        nz = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++)
            nz[k] = |snapshot[k*4 +: 4];
    end

    // Digit k is blankable when it and every higher nibble are zero.
    always_comb begin
        nibble       = '0;
        blank_cur    = 1'b0;
        digit_onehot = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (digit == DIG_W'(k)) begin
                nibble          = snapshot[k*4 +: 4];
                blank_cur       = blank_lz && (k != 0) && ((nz >> k) == '0);
                digit_onehot[k] = 1'b1;
            end
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc     <= '0;
            digit     <= '0;
            frame_cnt <= '0;
            snapshot  <= '0;
            cur_ch    <= '0;
            out7      <= BLANK_SEG;
            en_out    <= '1;
        end else begin
            presc <= tick ? '0 : presc + PRE_W'(1);
            if (!auto_rotate)
                frame_cnt <= '0;
            if (tick) begin
                out7   <= blank_cur ? BLANK_SEG : glyph;
                en_out <= blank_cur ? '1 : ~digit_onehot;
                digit  <= frame_end ? '0 : digit + DIG_W'(1);
                if (frame_end && !freeze) begin
                    cur_ch   <= next_ch;
                    snapshot <= sel_data;
                    if (auto_rotate)
                        frame_cnt <= (frame_cnt == FRM_W'(ROTATE_FRAMES - 1))
                                     ? '0 : frame_cnt + FRM_W'(1);
                end
            end
        end
    end

endmodule
